booth_iter_mult_ctrl: RTL and testbench
=======================================

Name: booth_iter_mult_ctrl

Overview:
Iterative signed radix-4 Booth multiplier controller. It time-shares a single Booth digit encoder and partial-product row across all WIDTH/2 multiplier digits, one digit per clock, and accumulates the shifted partial products into a 2*WIDTH product. It sits between an operand source and a result sink, with valid/ready handshakes on both sides. It is the area-optimised alternative to the fully parallel 16x16 Booth array.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4
CNT_W, 4, iteration-counter width; must satisfy 2^CNT_W >= WIDTH/2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a and b valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand, two's complement
b  input  WIDTH  multiplier, two's complement
out_valid  output  1  product valid
out_ready  input  1  sink accepts product
product  output  2*WIDTH  signed product a*b
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). With rst_n low, state=IDLE, in_ready=0 while asserted, then 1 from the first cycle after deassert; out_valid=0; product=0; busy=0; iteration counter=0; internal a/b/accumulator registers=0.
- Reset mid-operation aborts immediately. The in-flight result is discarded and no out_valid is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at an edge, latch a and b, clear the accumulator, set counter i=0, and go to CALC.
- CALC: in_ready=0, busy=1. Each edge processes digit i:
  - triplet = {b[2i+1], b[2i], b[2i-1]}, where b[-1]=0.
  - Encode 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
  - The partial product is WIDTH+2 bits, sign-extended to 2*WIDTH, shifted left by 2i, and added modulo 2^(2*WIDTH).
  - After digit WIDTH/2-1, go to DONE and load product from the accumulator.
- Latency: with acceptance at edge T, digits are processed at edges T+1..T+WIDTH/2. out_valid is high from edge T+WIDTH/2 (8 cycles for WIDTH=16).
- DONE: out_valid=1, busy=1. product is held stable until the handshake. On out_valid&out_ready, go to IDLE; out_valid clears on the next edge.
- in_ready is low in DONE, so no new operand is accepted in the same cycle as output handshake. Minimum initiation interval is WIDTH/2+2 cycles.
- Inputs a and b may change freely after acceptance; only the latched copies are used.
- product retains the last result while in IDLE.
- Arithmetic: full signed product, no overflow possible. -2^(W-1) * -2^(W-1) must give +2^(2W-2) exactly.
- Counter wrap: i never exceeds WIDTH/2-1. The CALC->DONE transition takes priority over increment.
- in_valid held high while busy has no effect.

Optional Feature:
Macro BOOTH_EARLY_TERM_EN.
- Defined: after processing digit i, if b[WIDTH-1 : 2i+1] are all equal (all remaining digits encode 0), the block goes to DONE at that edge. Latency is i+1 cycles (minimum 1). The check uses the latched b.
- Undefined: always WIDTH/2 CALC cycles. Product values are identical either way.

Test Plan:
- a=3, b=5 -> product=0x0000000F, out_valid exactly 8 cycles after accept (feature off).
- a=-1 (0xFFFF), b=-1 -> 0x00000001; a=0x8000, b=0x8000 -> 0x40000000; a=0x7FFF, b=0x8000 -> 0xC0008000.
- out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, product stable, in_ready 0; release -> IDLE next edge, in_ready=1.
- rst_n pulsed low at the 4th CALC cycle of a=100, b=200 -> outputs return to reset values at once, no out_valid. Next op a=100, b=200 -> 0x00004E20.
- BOOTH_EARLY_TERM_EN, a=7, b=3 -> product=0x00000015 after 2 CALC cycles. b=0 -> 0 after 1 cycle. b=0x8000 -> full 8 cycles, result correct.
- Random 1000 signed pairs with random out_ready stalls -> every product equals the reference a*b, and exactly one output per accepted input.

Source files
------------

// File: rtl/booth_iter_mult_ctrl.sv
// booth_iter_mult_ctrl: iterative signed radix-4 Booth multiplier.
// A single Booth digit encoder and partial-product row are reused for all
// WIDTH/2 multiplier digits, one digit per clock, accumulating a 2*WIDTH
// product.
//
// Handshakes: a transfer happens on any rising edge where valid and ready
// are both high. The source holds in_valid/a/b until in_ready is seen. The
// sink sees out_valid/product held until out_ready is seen.
//
// Optional feature, macro BOOTH_EARLY_TERM_EN: when defined, the block stops
// iterating as soon as every remaining multiplier digit encodes zero.
// Products are identical with or without it.
`timescale 1ns/1ps

module booth_iter_mult_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic [1:0]         dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int PW = WIDTH + 2;
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WIDTH/2 - 1);

   state_t               state_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 busy_q;

   logic [WIDTH:0]       b_ext;
   logic [2:0]           triplet;
   logic [PW-1:0]        a_ext;
   logic [PW-1:0]        pp;
   logic [2*WIDTH-1:0]   pp_shifted;
   logic [2*WIDTH-1:0]   acc_d;
   logic                 last_d;

   // Append the implicit b[-1]=0 so digit i reads bits [2i+2:2i] of b_ext.
   assign b_ext   = {b_q, 1'b0};
   assign triplet = b_ext[{cnt_q, 1'b0} +: 3];
   assign a_ext   = {{2{a_q[WIDTH-1]}}, a_q};

   // Booth digit encode: select 0, +-A or +-2A as a WIDTH+2 bit row.
   always_comb begin
      pp = '0;
      case (triplet)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = -(a_ext << 1);
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
   end

   // Sign-extend the row to 2*WIDTH, weight it by 4^i and accumulate.
   assign pp_shifted = {{(WIDTH-2){pp[PW-1]}}, pp} << {cnt_q, 1'b0};
   assign acc_d      = acc_q + pp_shifted;

`ifdef BOOTH_EARLY_TERM_EN
   logic rem_zero;

   // Remaining digits are all zero when b[WIDTH-1:2i+1] is a run of equal bits.
   always_comb begin
      rem_zero = 1'b1;
      for (int j = 0; j < WIDTH; j++) begin
         if ((j > 2*int'(cnt_q)) && (b_q[j] != b_q[WIDTH-1])) begin
            rem_zero = 1'b0;
         end
      end
   end

   assign last_d = (cnt_q == LAST_DIGIT) || rem_zero;
`else
   assign last_d = (cnt_q == LAST_DIGIT);
`endif

   // Control FSM with registered handshake outputs, operand latches and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         product_q   <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  state_q    <= ST_CALC;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            ST_CALC: begin
               acc_q <= acc_d;
               // Finishing takes priority over incrementing, so cnt_q never wraps.
               if (last_d) begin
                  state_q     <= ST_DONE;
                  product_q   <= acc_d;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign product     = product_q;
   assign busy        = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_iter_mult_ctrl.sv
// Testbench for booth_iter_mult_ctrl (WIDTH=16). Build with +define+BOOTH_EARLY_TERM_EN
// to cover the early-termination variant.
`timescale 1ns/1ps

module tb_booth_iter_mult_ctrl;

   localparam int W = 16;
`ifdef BOOTH_EARLY_TERM_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] product;
   logic           busy;
   logic [1:0]     dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   booth_iter_mult_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .product(product),
      .busy(busy), .dbg_state_o(dbg_state)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference helpers ----------------
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] av, input logic [W-1:0] bv);
      longint p;
      p = longint'($signed(av)) * longint'($signed(bv));
      return p[2*W-1:0];
   endfunction

   // Cycles from accept to out_valid: W/2, or first digit after which the rest of b is a sign run.
   function automatic int exp_latency(input logic [W-1:0] bv);
      int lat;
      bit eq;
      lat = W/2;
      for (int i = W/2 - 1; i >= 0; i--) begin
         eq = 1'b1;
         for (int j = 2*i + 1; j < W; j++) if (bv[j] != bv[W-1]) eq = 1'b0;
         if (eq) lat = i + 1;
      end
      return EARLY_EN ? lat : W/2;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv, output bit ok);
      a = av; b = bv; in_valid = 1'b1; ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (in_ready) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (ok) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
   endtask

   task automatic wait_valid(output int lat, output bit ok);
      lat = 0; ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (out_valid) begin ok = 1'b1; break; end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic take_output();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [2*W-1:0] got, output int lat, output bit ok);
      bit ok1, ok2;
      send_op(av, bv, ok1);
      wait_valid(lat, ok2);
      got = product;
      take_output();
      ok = ok1 && ok2;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_product: got %h want 0", product); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      logic [2*W-1:0] got; int lat; bit ok;
      run_op(16'd3, 16'd5, got, lat, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: got %b want 1", ok); end
      n_cmp++; if (got !== 32'h0000000F) begin n_err++; $display("FAIL basic_product: got %h want 0000000f", got); end
      n_cmp++; if (lat !== exp_latency(16'd5)) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_latency(16'd5)); end
   endtask

   task automatic test_corners();
      logic [W-1:0]   va[3] = '{16'hFFFF, 16'h8000, 16'h7FFF};
      logic [W-1:0]   vb[3] = '{16'hFFFF, 16'h8000, 16'h8000};
      logic [2*W-1:0] ve[3] = '{32'h00000001, 32'h40000000, 32'hC0008000};
      logic [2*W-1:0] got; int lat; bit ok;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], got, lat, ok);
         n_cmp++; if (ok !== 1'b1 || got !== ve[i]) begin n_err++; $display("FAIL corner_%0d: got %h ok=%b want %h", i, got, ok, ve[i]); end
         n_cmp++; if (lat !== exp_latency(vb[i])) begin n_err++; $display("FAIL corner_lat_%0d: got %0d want %0d", i, lat, exp_latency(vb[i])); end
      end
   endtask

   task automatic test_stall();
      int lat; bit ok1, ok2;
      send_op(16'hFFF9, 16'd9, ok1);
      wait_valid(lat, ok2);
      n_cmp++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL stall_timeout: got %b%b want 11", ok1, ok2); end
      // in_valid held high while busy must be ignored
      in_valid = 1'b1; a = 16'd1; b = 16'd1; out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid_%0d: got %b want 1", k, out_valid); end
         n_cmp++; if (product !== 32'hFFFFFFC1) begin n_err++; $display("FAIL stall_product_%0d: got %h want ffffffc1", k, product); end
         n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL stall_ready_busy_%0d: got %b%b want 01", k, in_ready, busy); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      take_output();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %b want 0", busy); end
      n_cmp++; if (product !== 32'hFFFFFFC1) begin n_err++; $display("FAIL release_hold: got %h want ffffffc1", product); end
   endtask

   task automatic test_reset_mid();
      logic [2*W-1:0] got; int lat; bit ok; bit seen;
      send_op(16'd100, 16'd200, ok);
      repeat (3) begin @(posedge clk); #1; end
      n_cmp++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL midreset_precalc: got %0d want 1", dbg_state); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL midreset_ctrl: got v%b b%b r%b want 000", out_valid, busy, in_ready); end
      n_cmp++; if (product !== '0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL midreset_state: got %h/%0d want 0/0", product, dbg_state); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_no_output: got %b want 0", seen); end
      run_op(16'd100, 16'd200, got, lat, ok);
      n_cmp++; if (ok !== 1'b1 || got !== 32'h00004E20) begin n_err++; $display("FAIL midreset_next_op: got %h ok=%b want 00004e20", got, ok); end
   endtask

`ifdef BOOTH_EARLY_TERM_EN
   task automatic test_early_term();
      logic [W-1:0]   va[3] = '{16'd7, 16'd1234, 16'd5};
      logic [W-1:0]   vb[3] = '{16'd3, 16'd0, 16'h8000};
      logic [2*W-1:0] ve[3] = '{32'h00000015, 32'h00000000, 32'hFFFD8000};
      int             vl[3] = '{2, 1, 8};
      logic [2*W-1:0] got; int lat; bit ok;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], got, lat, ok);
         n_cmp++; if (ok !== 1'b1 || got !== ve[i]) begin n_err++; $display("FAIL early_product_%0d: got %h want %h", i, got, ve[i]); end
         n_cmp++; if (lat !== vl[i]) begin n_err++; $display("FAIL early_latency_%0d: got %0d want %0d", i, lat, vl[i]); end
      end
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] av, bv; logic [2*W-1:0] exp_p;
      int lat, n_acc, n_out, stall; bit ok1, ok2;
      n_acc = 0; n_out = 0;
      for (int n = 0; n < 1000; n++) begin
         av = W'($urandom); bv = W'($urandom);
         if (n % 50 == 0) av = 16'h8000;
         if (n % 70 == 0) bv = 16'h0000;
         send_op(av, bv, ok1);
         if (ok1) begin n_acc++; exp_q.push_back(ref_mul(av, bv)); end
         wait_valid(lat, ok2);
         n_cmp++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL rand_timeout_%0d: got %b%b want 11", n, ok1, ok2); end
         n_cmp++; if (lat !== exp_latency(bv)) begin n_err++; $display("FAIL rand_latency_%0d: got %0d want %0d", n, lat, exp_latency(bv)); end
         stall = $urandom_range(0, 3);
         repeat (stall) begin @(posedge clk); #1; end
         if (out_valid && exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            n_out++;
            n_cmp++; if (product !== exp_p) begin n_err++; $display("FAIL rand_product_%0d: a=%h b=%h got %h want %h", n, av, bv, product, exp_p); end
         end
         take_output();
      end
      n_cmp++; if (n_acc !== n_out || exp_q.size() !== 0) begin n_err++; $display("FAIL rand_count: got %0d outputs for %0d accepts", n_out, n_acc); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_stall();
      test_reset_mid();
`ifdef BOOTH_EARLY_TERM_EN
      test_early_term();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
